// File: rtl/if_pkg.sv
// if_pkg: shared constants and types for the instruction-fetch stage.
package if_pkg;
    localparam logic [31:0] NOP_INSTR = 32'h0;
    localparam logic [31:0] PC_STEP = 32'd4;
    typedef enum logic [1:0] {FETCH, WAIT, DROP} fetch_state_e;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } fetch_entry_t;
endpackage

// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: instruction-memory request (valid/ready) and response (rvalid) channel.
interface if_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    modport master (output imem_req, imem_addr, input imem_ready, imem_rvalid, imem_rdata);
    modport slave (input imem_req, imem_addr, output imem_ready, imem_rvalid, imem_rdata);
endinterface

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: power-of-two FIFO of fetched {pc, ir} entries; flush beats push.
module if_fetch_queue
    import if_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fetch_entry_t  push_entry,
    output logic [CW-1:0] count,
    output fetch_entry_t  head
);
    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    always_comb begin
        rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(pop);
        wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(push);
        count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q <= count_d;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst && push && !flush) mem_q[wr_ptr_q] <= push_entry;
    end
    assign count = count_q;
    assign head = mem_q[rd_ptr_q];
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: fetch PC, single-outstanding imem request FSM and IF-side IR/PC outputs.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int BUF_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    if_fetch_unit_if.master        imem,
    output logic                   if_valid,
    output logic [31:0]            IR_IF,
    output logic [31:0]            PC_IF
);
    localparam int CW = $clog2(BUF_DEPTH) + 1;
    fetch_state_e  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d, req_pc_q, req_pc_d;
    logic [CW-1:0] count;
    fetch_entry_t  head, push_entry;
    logic          accept, push, pop;
    // A request only issues while a queue slot is free, so every response has room.
    assign imem.imem_req = !rst && state_q == FETCH && !redirect && count < CW'(BUF_DEPTH);
    assign imem.imem_addr = fetch_pc_q;
    assign accept = imem.imem_req && imem.imem_ready;
    assign push = state_q == WAIT && imem.imem_rvalid && !redirect;
    assign pop = if_valid && !stall && !redirect;
    assign push_entry = '{pc: req_pc_q, ir: imem.imem_rdata};
    if_fetch_queue #(.DEPTH(BUF_DEPTH)) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .flush      (redirect),
        .push_entry (push_entry),
        .count      (count),
        .head       (head)
    );
    always_comb begin
        state_d = state_q;
        if (redirect) state_d = (state_q == FETCH || imem.imem_rvalid) ? FETCH : DROP;
        else if (accept) state_d = WAIT;
        else if (state_q != FETCH && imem.imem_rvalid) state_d = FETCH;
        fetch_pc_d = redirect ? {redirect_pc[31:2], 2'b00} : accept ? fetch_pc_q + PC_STEP : fetch_pc_q;
        req_pc_d = accept ? fetch_pc_q : req_pc_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            fetch_pc_q <= RESET_PC;
            req_pc_q <= RESET_PC;
        end else begin
            state_q <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q <= req_pc_d;
        end
    end
    assign if_valid = count != '0;
    assign IR_IF = if_valid ? head.ir : NOP_INSTR;
    assign PC_IF = if_valid ? head.pc : 32'h0;
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: scoreboard bench with a latency-programmable instruction-memory responder.
module tb_if_fetch_unit;
    import if_pkg::*;
    localparam logic [31:0] K = 32'hA5A5_0000;
    logic clk = 0, rst = 1, stall = 0, redirect = 0;
    logic [31:0] redirect_pc = 0;
    logic if_valid, if_valid2;
    logic [31:0] IR_IF, PC_IF, ir2, pc2;
    int n_tests = 0, n_fail = 0;
    int lat = 1, rcnt = 0;
    logic [31:0] raddr = 0, raddr2 = 0, exp_pc = 0;
    logic keep = 0, acc2 = 0, found;
    fetch_entry_t sb[$];
    logic [31:0] popped[$], addrs2[$], pcs2[$];

    if_fetch_unit_if bus();
    if_fetch_unit_if bus2();

    if_fetch_unit #(.RESET_PC(32'h0), .BUF_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem(bus), .if_valid(if_valid), .IR_IF(IR_IF), .PC_IF(PC_IF)
    );
    if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) dut2 (
        .clk(clk), .rst(rst), .stall(1'b0), .redirect(1'b0), .redirect_pc(32'h0),
        .imem(bus2), .if_valid(if_valid2), .IR_IF(ir2), .PC_IF(pc2)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_pops(string tag, logic [31:0] a, logic [31:0] b, logic [31:0] c);
        chk({tag, "_npop"}, 32'(popped.size() >= 3), 32'd1);
        if (popped.size() >= 3) begin
            chk({tag, "_pop0"}, popped[0], a);
            chk({tag, "_pop1"}, popped[1], b);
            chk({tag, "_pop2"}, popped[2], c);
        end
    endtask

    task automatic wait_valid(string tag, int lim);
        for (int i = 0; i < lim && !if_valid; i++) @(negedge clk);
        chk(tag, 32'(if_valid), 32'd1);
    endtask

    task automatic do_reset();
        step();
        rst = 1;
        step();
        rst = 0;
    endtask

    // Memory responder: rvalid lat cycles after an accepted request.
    always @(posedge clk) begin
        #1;
        bus.imem_rvalid = 0;
        if (rcnt > 0) begin
            rcnt--;
            if (rcnt == 0) begin
                bus.imem_rvalid = 1;
                bus.imem_rdata = raddr ^ K;
            end
        end
        bus2.imem_rvalid = acc2;
        bus2.imem_rdata = raddr2 ^ K;
    end

    // Monitor and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin : mon
        fetch_entry_t e;
        acc2 = !rst && bus2.imem_req && bus2.imem_ready;
        if (acc2) begin
            raddr2 = bus2.imem_addr;
            if (addrs2.size() < 3) addrs2.push_back(raddr2);
        end
        if (!rst && if_valid2 && pcs2.size() < 3) begin
            pcs2.push_back(pc2);
            chk("dut2_ir", ir2, pc2 ^ K);
        end
        if (rst) begin
            sb.delete();
            keep = 0;
            exp_pc = 32'h0;
        end else begin
            if (!if_valid) begin
                chk("nop_ir", IR_IF, NOP_INSTR);
                chk("nop_pc", PC_IF, 32'h0);
            end
            if (if_valid && !stall && !redirect) begin
                if (sb.size() == 0) chk("pop_without_expect", 32'(if_valid), 32'd0);
                else begin
                    e = sb.pop_front();
                    chk("pop_pc", PC_IF, e.pc);
                    chk("pop_ir", IR_IF, e.ir);
                end
                popped.push_back(PC_IF);
            end
            if (redirect) begin
                chk("req_on_redirect", 32'(bus.imem_req), 32'd0);
                sb.delete();
                keep = 0;
                exp_pc = {redirect_pc[31:2], 2'b00};
            end else if (bus.imem_rvalid && keep) begin
                sb.push_back('{pc: raddr, ir: raddr ^ K});
                keep = 0;
            end
            if (bus.imem_req && bus.imem_ready && !redirect) begin
                chk("req_addr", bus.imem_addr, exp_pc);
                exp_pc += 32'd4;
                keep = 1;
                raddr = bus.imem_addr;
                rcnt = lat;
            end
        end
    end

    initial begin
        bus.imem_ready = 1; bus.imem_rvalid = 0; bus.imem_rdata = 0;
        bus2.imem_ready = 1; bus2.imem_rvalid = 0; bus2.imem_rdata = 0;
        // Test 1: reset state, then streaming fetch from 0.
        step();
        step();
        @(negedge clk);
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_ir", IR_IF, 32'h0);
        chk("rst_pc", PC_IF, 32'h0);
        chk("rst_addr", bus.imem_addr, 32'h0);
        step();
        rst = 0;
        popped.delete();
        @(negedge clk);
        chk("t1_req", 32'(bus.imem_req), 32'd1);
        chk("t1_addr", bus.imem_addr, 32'h0);
        @(negedge clk);
        chk("t1_valid_c1", 32'(if_valid), 32'd0);
        @(negedge clk);
        chk("t1_valid_c2", 32'(if_valid), 32'd1);
        chk("t1_first_pc", PC_IF, 32'h0);
        chk("t1_first_ir", IR_IF, 32'hA5A5_0000);
        repeat (6) @(negedge clk);
        check_pops("t1", 32'h0, 32'h4, 32'h8);
        // Test 2: stall from reset fills the queue, then drains in order.
        stall = 1;
        do_reset();
        popped.delete();
        repeat (10) step();
        @(negedge clk);
        chk("t2_full_valid", 32'(if_valid), 32'd1);
        chk("t2_full_pc", PC_IF, 32'h0);
        chk("t2_full_req", 32'(bus.imem_req), 32'd0);
        step();
        stall = 0;
        repeat (8) @(negedge clk);
        check_pops("t2", 32'h0, 32'h4, 32'h8);
        // Test 3: redirect while waiting on 0x10.
        lat = 3;
        do_reset();
        found = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.imem_req && bus.imem_ready && bus.imem_addr == 32'h10) begin
                found = 1;
                break;
            end
        end
        chk("t3_found_0x10", 32'(found), 32'd1);
        step();
        redirect = 1;
        redirect_pc = 32'h0000_0103;
        step();
        redirect = 0;
        popped.delete();
        @(negedge clk);
        chk("t3_flushed", 32'(if_valid), 32'd0);
        wait_valid("t3_valid_timeout", 30);
        chk("t3_nopop", popped.size(), 32'd0);
        chk("t3_pc", PC_IF, 32'h100);
        chk("t3_ir", IR_IF, 32'h100 ^ K);
        // Test 4: redirect coincides with rvalid and a non-empty queue.
        lat = 1;
        stall = 1;
        do_reset();
        step();
        step();
        step();
        redirect = 1;
        redirect_pc = 32'h0000_0200;
        @(negedge clk);
        chk("t4_rvalid", 32'(bus.imem_rvalid), 32'd1);
        chk("t4_nonempty", 32'(if_valid), 32'd1);
        step();
        redirect = 0;
        stall = 0;
        @(negedge clk);
        chk("t4_flushed", 32'(if_valid), 32'd0);
        chk("t4_req", 32'(bus.imem_req), 32'd1);
        chk("t4_addr", bus.imem_addr, 32'h200);
        // Test 6: reset mid-WAIT with a stray response afterwards.
        lat = 3;
        do_reset();
        step();
        rst = 1;
        bus.imem_ready = 0;
        step();
        rst = 0;
        @(negedge clk);
        chk("t6_valid", 32'(if_valid), 32'd0);
        chk("t6_ir", IR_IF, 32'h0);
        chk("t6_pc", PC_IF, 32'h0);
        chk("t6_addr", bus.imem_addr, 32'h0);
        chk("t6_req", 32'(bus.imem_req), 32'd1);
        step();
        @(negedge clk);
        chk("t6_stray_rvalid", 32'(bus.imem_rvalid), 32'd1);
        step();
        bus.imem_ready = 1;
        @(negedge clk);
        chk("t6_stray_ignored", 32'(if_valid), 32'd0);
        wait_valid("t6_valid_timeout", 30);
        chk("t6_pc_restart", PC_IF, 32'h0);
        chk("t6_ir_restart", IR_IF, K);
        // Test 5: second instance with RESET_PC near the top wraps.
        chk("t5_naddr", addrs2.size(), 32'd3);
        chk("t5_npc", pcs2.size(), 32'd3);
        if (addrs2.size() == 3 && pcs2.size() == 3) begin
            chk("t5_addr0", addrs2[0], 32'hFFFF_FFF8);
            chk("t5_addr1", addrs2[1], 32'hFFFF_FFFC);
            chk("t5_addr2", addrs2[2], 32'h0000_0000);
            chk("t5_pc0", pcs2[0], 32'hFFFF_FFF8);
            chk("t5_pc2", pcs2[2], 32'h0000_0000);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage that drives the IF side of the IF/ID pipeline register (IR_IF, PC_IF).
- Keeps the fetch PC and issues one instruction-memory request at a time over a valid/ready request and rvalid response handshake.
- Buffers returned instructions in a 2-entry queue; honours the downstream stall and redirects (branch/jump/flush) from EX.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset; bits [1:0] must be 0.
BUF_DEPTH, 2, fetched-instruction queue depth (legal values 2 or 4).

Ports:
clk  in  1  clock; all state updates on posedge.
rst  in  1  synchronous, active-high reset.
stall  in  1  IF/ID cannot accept this cycle; head entry is held.
redirect  in  1  flush queue and restart fetch at redirect_pc.
redirect_pc  in  32  new fetch address; bits [1:0] forced to 0.
imem_req  out  1  request valid.
imem_addr  out  32  request word address (byte address, word aligned).
imem_ready  in  1  memory accepts the request this cycle.
imem_rvalid  in  1  response data valid.
imem_rdata  in  32  instruction word.
if_valid  out  1  IR_IF/PC_IF hold a real instruction.
IR_IF  out  32  instruction to IF/ID; 32'h0 (NOP) when if_valid=0.
PC_IF  out  32  PC of IR_IF; 0 when if_valid=0.

Behaviour:
- Reset (synchronous):
  - fetch_pc=RESET_PC, queue empty, state=FETCH, no outstanding request.
  - Outputs: imem_req=0, if_valid=0, IR_IF=0, PC_IF=0. imem_addr shows RESET_PC.
  - Reset overrides all other inputs. Reset during WAIT/DROP abandons the request; a later stray rvalid in FETCH is ignored.
- States:
  - FETCH: no outstanding request.
  - WAIT: one request outstanding; its response is kept.
  - DROP: one request outstanding; its response is discarded.
- Request issue:
  - imem_req = (state==FETCH) & !redirect & (count < BUF_DEPTH). The reserved slot guarantees every response has a free entry.
  - imem_addr = fetch_pc.
  - On imem_req & imem_ready: latch req_pc=fetch_pc, fetch_pc += 4 (wraps 32'hFFFF_FFFC -> 0), go to WAIT.
  - imem_req stays high without ready; the address is held stable.
- Response:
  - In WAIT, imem_rvalid pushes {req_pc, imem_rdata} into the queue and returns to FETCH.
  - A new request may issue the cycle after rvalid; back-to-back throughput is 1 instruction per 2 cycles.
  - In DROP, rvalid is discarded and the state returns to FETCH.
  - rvalid in FETCH is ignored.
- Output:
  - if_valid = queue non-empty; IR_IF/PC_IF = head entry, combinationally from queue storage.
  - Pop on if_valid & !stall & !redirect.
  - Minimum latency from accept edge to IR_IF valid: response in cycle +1, visible in cycle +2.
- Redirect (priority: rst > redirect > rvalid/pop):
  - Queue is cleared; fetch_pc = {redirect_pc[31:2],2'b00}; imem_req is low that cycle.
  - WAIT goes to DROP; DROP stays DROP; FETCH stays FETCH.
  - An rvalid in the same cycle as redirect is discarded.
  - First request to redirect_pc goes out the next cycle (FETCH) or the cycle after the dropped response (DROP).
- Simultaneous push and pop: both happen; count is unchanged.
- Full queue with stall held: no new request issues; contents are retained indefinitely.
- Stall does not affect an outstanding request.

Decomposition:
- Shared package if_pkg:
  - NOP_INSTR=32'h0, PC_STEP=32'd4.
  - Fetch state enum {FETCH, WAIT, DROP}.
  - Fetch-entry struct {pc[31:0], ir[31:0]}.
- One sub-module, if_fetch_queue:
  - Parameterised BUF_DEPTH FIFO of fetch entries.
  - push, pop, flush, count, head outputs; flush has priority over push.

Test Plan:
1. Reset, imem_ready=1, fixed 1-cycle rvalid, rdata=addr^32'hA5A5_0000 -> requests to 0,4,8; IR_IF/PC_IF sequence {0xA5A5_0000,0},{0xA5A5_0004,4},{0xA5A5_0008,8}; first if_valid 2 cycles after first accept.
2. stall=1 for 10 cycles from reset -> queue fills to 2 (PC 0,4), imem_req drops to 0, head holds PC_IF=0. Release -> PC 0,4,8 delivered in order with no loss or duplicate.
3. redirect=1 with redirect_pc=32'h0000_0103 while in WAIT for addr 0x10 -> rdata for 0x10 never reaches IR_IF; next imem_addr=0x100; queue empty until the 0x100 response arrives.
4. redirect asserted in the same cycle as rvalid and with a non-empty queue -> if_valid=0 the next cycle; next request to the redirect target.
5. RESET_PC=32'hFFFF_FFF8 -> requests FFFF_FFF8, FFFF_FFFC, 0000_0000 (PC wrap).
6. rst asserted in WAIT, stray rvalid 2 cycles later -> ignored; outputs 0; fetch restarts at RESET_PC.
